// File: rtl/lbm_arb_pkg.sv
// lbm_arb_pkg: shared state type, requester count and source codes for the 3-way arbiter
package lbm_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int NUM_REQ = 3;
  localparam logic [1:0] SRC0 = 2'b00;
  localparam logic [1:0] SRC1 = 2'b01;
  localparam logic [1:0] SRC2 = 2'b10;
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC2) ? SRC0 : s + 2'd1;
  endfunction
endpackage

// File: rtl/mux3_arbiter_rr_pick3.sv
// rr_pick3: round-robin search of three valid bits starting at ptr, wrapping modulo 3
module rr_pick3
  import lbm_arb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] winner
);
  logic [3:0] valid_pad;
  logic [1:0] p0, p1, p2;
  // Winner is never 2'b11: an illegal ptr is folded onto SRC0 before the search
  always_comb begin
    valid_pad = {1'b0, valid};
    p0 = (ptr == 2'b11) ? SRC0 : ptr;
    p1 = next_src(p0);
    p2 = next_src(p1);
    found = |valid;
    winner = valid_pad[p0] ? p0 : valid_pad[p1] ? p1 : valid_pad[p2] ? p2 : p0;
  end
endmodule

// File: rtl/mux3_arbiter.sv
// mux3_arbiter: burst-aware round-robin 3:1 mux with a one-word registered output stage
module mux3_arbiter
  import lbm_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   in_valid,
  input  logic [2:0]                   in_last,
  input  logic signed [DATA_WIDTH-1:0] din0,
  input  logic signed [DATA_WIDTH-1:0] din1,
  input  logic signed [DATA_WIDTH-1:0] din2,
  output logic [2:0]                   in_ready,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [1:0]                   dout_src,
  output logic                         dout_last
);
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, owner, owner_n, sel, winner;
  logic found, req, grant, load_en, sel_last;
  logic [3:0] valid_pad, last_pad;
  logic signed [DATA_WIDTH-1:0] sel_data;
  assign load_en = !dout_valid | dout_ready;
  rr_pick3 u_pick (
    .valid (in_valid),
    .ptr   (ptr),
    .found (found),
    .winner(winner)
  );
  // Grant selection and next arbitration state; a burst owner locks out everyone else
  always_comb begin
    valid_pad = {1'b0, in_valid};
    last_pad = {1'b0, in_last};
    sel = (state == BURST) ? owner : winner;
    req = (state == BURST) ? valid_pad[sel] : found;
    grant = !reset & load_en & req;
    sel_last = last_pad[sel];
    sel_data = (sel == SRC2) ? din2 : (sel == SRC1) ? din1 : din0;
    in_ready = grant ? (3'b001 << sel) : 3'b000;
    state_n = grant ? (sel_last ? IDLE : BURST) : state;
    owner_n = (grant & !sel_last) ? sel : owner;
    ptr_n = (grant & sel_last) ? next_src(sel) : ptr;
  end
  // Arbitration state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= SRC0;
      owner <= SRC0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
    end
  end
  // Output word register: load on grant, otherwise drop valid once drained
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
      dout_valid <= 1'b0;
      dout_src <= SRC0;
      dout_last <= 1'b0;
    end else if (grant) begin
      dout <= sel_data;
      dout_valid <= 1'b1;
      dout_src <= sel;
      dout_last <= sel_last;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux3_arbiter.sv
// tb_mux3_arbiter: scoreboard bench with an independent arbitration model and directed plus random steps
module tb_mux3_arbiter;
  typedef struct {
    logic signed [31:0] d;
    logic [1:0] s;
    logic l;
  } beat_t;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] in_valid, in_last, in_ready;
  logic signed [31:0] d [3];
  logic signed [31:0] dout;
  logic dout_valid, dout_ready, dout_last;
  logic [1:0] dout_src;
  beat_t q[$];
  int n_chk = 0;
  int n_err = 0;
  int mst = 0;
  int mptr = 0;
  int mown = 0;
  always #5 clk = ~clk;
  mux3_arbiter #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .din0      (d[0]),
    .din1      (d[1]),
    .din2      (d[2]),
    .in_ready  (in_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_src  (dout_src),
    .dout_last (dout_last)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    logic le;
    bit g;
    int idx;
    @(negedge clk);
    le = (q.size() == 0) || dout_ready;
    g = 0;
    idx = 0;
    if (!reset && le) begin
      if (mst == 1) begin
        if (in_valid[mown]) begin
          g = 1;
          idx = mown;
        end
      end else begin
        for (int k = 0; k < 3; k++)
          if (!g && in_valid[(mptr + k) % 3]) begin
            g = 1;
            idx = (mptr + k) % 3;
          end
      end
    end
    chk("in_ready", {29'd0, in_ready}, g ? (32'd1 << idx) : 32'd0);
    chk("dout_valid", {31'd0, dout_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("dout", dout, q[0].d);
      chk("dout_src", {30'd0, dout_src}, {30'd0, q[0].s});
      chk("dout_last", {31'd0, dout_last}, {31'd0, q[0].l});
      if (dout_ready) void'(q.pop_front());
    end
    if (g) begin
      q.push_back('{d[idx], 2'(idx), in_last[idx]});
      if (in_last[idx]) begin
        mst = 0;
        mptr = (idx + 1) % 3;
      end else begin
        mst = 1;
        mown = idx;
      end
    end
    if (reset) begin
      q.delete();
      mst = 0;
      mptr = 0;
      mown = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 3'b111;
    in_last = 3'b111;
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    cyc();
    cyc();
    chk("rst_dout", dout, 32'd0);
    chk("rst_src", {30'd0, dout_src}, 32'd0);
    chk("rst_last", {31'd0, dout_last}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[0] = 32'h100 + i;
      d[1] = 32'h200 + i;
      d[2] = 32'h300 + i;
      cyc();
    end
    in_last = 3'b101;
    for (int i = 0; i < 3; i++) begin
      d[1] = -5 - i;
      cyc();
    end
    in_last = 3'b111;
    d[1] = -8;
    cyc();
    cyc();
    cyc();
    d[0] = 32'h7FFFFFFF;
    d[1] = 32'h7FFFFFFF;
    d[2] = 32'h7FFFFFFF;
    cyc();
    dout_ready = 1'b0;
    d[0] = 32'h80000000;
    d[1] = 32'h80000001;
    d[2] = 32'h80000002;
    cyc();
    cyc();
    cyc();
    dout_ready = 1'b1;
    cyc();
    cyc();
    in_valid = 3'b100;
    in_last = 3'b000;
    d[2] = 32'h2222;
    cyc();
    in_valid = 3'b011;
    cyc();
    cyc();
    in_valid = 3'b111;
    in_last = 3'b100;
    d[2] = 32'h2223;
    cyc();
    in_last = 3'b111;
    cyc();
    cyc();
    in_valid = 3'b001;
    in_last = 3'b000;
    d[0] = 32'hA5A5;
    cyc();
    cyc();
    dout_ready = 1'b0;
    reset = 1'b1;
    in_valid = 3'b111;
    cyc();
    chk("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    reset = 1'b0;
    dout_ready = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 400; i++) begin
      in_valid = 3'($urandom);
      in_last = 3'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) == 0);
      for (int j = 0; j < 3; j++) d[j] = $urandom;
      cyc();
    end
    reset = 1'b0;
    in_valid = 3'b000;
    dout_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mux3_arbiter.md
MUX3_ARBITER -- requirements
Module: mux3_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of all signed data words.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  3  per-requester word valid; bit i is requester i.
REQ-005 SHALL have port in_last  input  3  per-requester end-of-burst marker, qualified by in_valid.
REQ-006 SHALL have ports din0, din1, din2  input  DATA_WIDTH signed  requester data words.
REQ-007 SHALL have port in_ready  output  3  per-requester accept; always one-hot or zero.
REQ-008 SHALL have port dout  output  DATA_WIDTH signed  registered selected word.
REQ-009 SHALL have port dout_valid  output  1  dout holds an undelivered word.
REQ-010 SHALL have port dout_ready  input  1  downstream accept.
REQ-011 SHALL have port dout_src  output  2  source of dout: 00=din0, 01=din1, 10=din2.
REQ-012 SHALL have port dout_last  output  1  registered copy of accepted in_last bit.

Function
REQ-013 SHALL treat input beat i as transferred when in_valid[i] & in_ready[i]; output beat when dout_valid & dout_ready.
REQ-014 SHALL define load_en = !dout_valid | dout_ready; in_ready SHALL be all-zero when load_en is 0.
REQ-015 SHALL use states IDLE and BURST, plus 2-bit round-robin pointer ptr (values 0..2) and 2-bit owner.
REQ-016 In IDLE, winner SHALL be the first requester with in_valid set, searching ptr, ptr+1, ptr+2 modulo 3; in_ready[winner]=load_en.
REQ-017 In IDLE, accepted beat with in_last=0 SHALL move to BURST with owner=winner; with in_last=1 SHALL stay IDLE.
REQ-018 In BURST, in_ready SHALL be asserted only for owner (when load_en); other requesters' in_valid SHALL be ignored.
REQ-019 In BURST, owner deasserting in_valid SHALL insert a bubble and hold BURST; accepted beat with in_last=1 SHALL return to IDLE.
REQ-020 On every accepted beat with in_last=1, ptr SHALL become (source+1) mod 3.
REQ-021 Internal mux select SHALL take only values 00, 01, 10; 11 SHALL never be generated.
REQ-022 Accepted beat SHALL appear on dout/dout_src/dout_last exactly 1 cycle later, dout_valid=1.
REQ-023 While dout_valid & !dout_ready, dout, dout_src, dout_last SHALL hold stable and no input SHALL be accepted.
REQ-024 Output drain and new load in the same cycle SHALL both occur, sustaining 1 beat/cycle.
REQ-025 Output drain with no accepted input SHALL clear dout_valid next cycle; dout value SHALL be don't-care.
REQ-026 A requester holding in_valid continuously SHALL be granted after at most 2 other bursts complete.
REQ-027 Data SHALL pass unmodified; no sign extension, truncation or arithmetic.

Reset
REQ-028 During reset, in_ready SHALL be 000 regardless of other inputs.
REQ-029 After reset: dout=0, dout_valid=0, dout_src=00, dout_last=0, state=IDLE, ptr=0, owner=0.
REQ-030 Reset mid-burst or with a held output word SHALL discard the word and abandon the burst; no resumption.

Structure
REQ-031 Package lbm_arb_pkg SHALL hold the state typedef (IDLE, BURST), NUM_REQ=3, and source codes SRC0=2'b00, SRC1=2'b01, SRC2=2'b10.
REQ-032 Combinational winner search SHALL be sub-module rr_pick3 (inputs: valid[2:0], ptr; outputs: found, winner[1:0]).

Verification
REQ-033 All in_valid=111, in_last=111, dout_ready=1 after reset -> dout_src sequence 00,01,10,00 with dout_valid=1 each cycle.
REQ-034 Requester 1 sends 4 beats (last on 4th), din1=-5,-6,-7,-8, others valid -> in_ready=010 for 4 accepts; dout -5..-8 contiguous, dout_last only on -8; next grant is 10.
REQ-035 dout_ready=0 for 3 cycles with dout=0x7FFFFFFF held -> dout stable, in_ready=000; on dout_ready=1, next word loads same cycle.
REQ-036 Owner 2 drops in_valid mid-burst while 0 and 1 valid -> in_ready=000 (bubble), state stays BURST until requester 2 finishes.
REQ-037 reset asserted during burst from requester 0 with dout_valid=1 -> next cycle dout_valid=0, in_ready=000; after release, ptr=0 so requester 0 wins if valid.
